// File: rtl/dec_entry_if.sv
// Pulse inputs and accumulator outputs of the decimal-entry block.
// The bcd signal exists only when DEC_ENTRY_BCD_EN is defined.
`timescale 1ns/1ps
interface dec_entry_if #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) ();
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic             inc_pulse;
  logic             dec_pulse;
  logic             commit_pulse;
  logic             clr_pulse;
  logic [3:0]       digit;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] value;
  logic             full;
  logic             ovf;
  logic             commit_ack;
`ifdef DEC_ENTRY_BCD_EN
  logic [MAX_DIGITS*4-1:0] bcd;
`endif

  modport master (
`ifdef DEC_ENTRY_BCD_EN
    input  bcd,
`endif
    output inc_pulse, dec_pulse, commit_pulse, clr_pulse,
    input  digit, count, value, full, ovf, commit_ack
  );

  modport slave (
`ifdef DEC_ENTRY_BCD_EN
    output bcd,
`endif
    input  inc_pulse, dec_pulse, commit_pulse, clr_pulse,
    output digit, count, value, full, ovf, commit_ack
  );
endinterface

// File: rtl/dec_entry.sv
// Decimal-entry accumulator: builds a pending digit and folds commits into value = value*10 + digit.
// Optional DEC_ENTRY_BCD_EN adds a BCD shift register of the committed digits.
`timescale 1ns/1ps
module dec_entry #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5,
  localparam int CW        = $clog2(MAX_DIGITS + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  dec_entry_if.slave  bus
);
  typedef enum logic [1:0] {EMPTY, ENTRY, FULL, ERROR} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       digit_reg, digit_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] value_reg, value_next;
  logic             full_reg, full_next;
  logic             ovf_reg, ovf_next;
  logic             ack_reg, ack_next;
`ifdef DEC_ENTRY_BCD_EN
  logic [MAX_DIGITS*4-1:0] bcd_reg, bcd_next;
`endif

  logic [WIDTH+3:0] value_ext;
  logic [WIDTH+3:0] sum;
  logic             sum_fits;
  logic [CW-1:0]    count_inc;
  logic [3:0]       digit_adj;

  // value*10 as two shifts plus the digit, with 4 bits of headroom to detect overflow
  always_comb begin
    value_ext = {4'b0000, value_reg};
    sum       = (value_ext << 3) + (value_ext << 1) + {{WIDTH{1'b0}}, digit_reg};
    sum_fits  = (sum[WIDTH+3:WIDTH] == 4'd0);
    count_inc = count_reg + CW'(1);
  end

  always_comb begin
    digit_adj = digit_reg;
    if (bus.inc_pulse && !bus.dec_pulse)
      digit_adj = (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
    else if (bus.dec_pulse && !bus.inc_pulse)
      digit_adj = (digit_reg == 4'd0) ? 4'd9 : digit_reg - 4'd1;
  end

  always_comb begin
    state_next = state_reg;
    digit_next = digit_reg;
    count_next = count_reg;
    value_next = value_reg;
    full_next  = full_reg;
    ovf_next   = ovf_reg;
    ack_next   = 1'b0;
`ifdef DEC_ENTRY_BCD_EN
    bcd_next   = bcd_reg;
`endif
    if (bus.clr_pulse) begin
      state_next = EMPTY;
      digit_next = 4'd0;
      count_next = '0;
      value_next = '0;
      full_next  = 1'b0;
      ovf_next   = 1'b0;
`ifdef DEC_ENTRY_BCD_EN
      bcd_next   = '0;
`endif
    end else begin
      case (state_reg)
        EMPTY, ENTRY: begin
          if (bus.commit_pulse) begin
            if (sum_fits) begin
              value_next = sum[WIDTH-1:0];
              count_next = count_inc;
              digit_next = 4'd0;
              ack_next   = 1'b1;
              full_next  = (count_inc == CW'(MAX_DIGITS));
              state_next = (count_inc == CW'(MAX_DIGITS)) ? FULL : ENTRY;
`ifdef DEC_ENTRY_BCD_EN
              bcd_next   = {bcd_reg[MAX_DIGITS*4-5:0], digit_reg};
`endif
            end else begin
              // Rejected commit: everything but the flag is frozen, inc/dec dropped too
              ovf_next   = 1'b1;
              state_next = ERROR;
            end
          end else begin
            digit_next = digit_adj;
          end
        end
        FULL:    digit_next = digit_adj;
        ERROR:   ;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      digit_reg <= 4'd0;
      count_reg <= '0;
      value_reg <= '0;
      full_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      ack_reg   <= 1'b0;
`ifdef DEC_ENTRY_BCD_EN
      bcd_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      digit_reg <= digit_next;
      count_reg <= count_next;
      value_reg <= value_next;
      full_reg  <= full_next;
      ovf_reg   <= ovf_next;
      ack_reg   <= ack_next;
`ifdef DEC_ENTRY_BCD_EN
      bcd_reg   <= bcd_next;
`endif
    end
  end

  assign bus.digit      = digit_reg;
  assign bus.count      = count_reg;
  assign bus.value      = value_reg;
  assign bus.full       = full_reg;
  assign bus.ovf        = ovf_reg;
  assign bus.commit_ack = ack_reg;
`ifdef DEC_ENTRY_BCD_EN
  assign bus.bcd        = bcd_reg;
`endif
endmodule

// File: tb/tb_dec_entry.sv
// Bench for dec_entry: directed scenarios plus randomized pulses against an arithmetic reference model.
`timescale 1ns/1ps
module tb_dec_entry;
  localparam int WIDTH = 16;
  localparam int MAXD  = 5;
  localparam int CW    = $clog2(MAXD + 1);
  localparam int VMAX  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dec_entry_if #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) bus ();
  dec_entry #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int dut_acks = 0;

  // reference model state: plain integers
  int m_value, m_count, m_digit;
  bit m_ovf, m_ack;
  logic [MAXD*4-1:0] m_bcd;

  task automatic model_reset();
    m_value = 0; m_count = 0; m_digit = 0; m_ovf = 0; m_ack = 0; m_bcd = '0;
  endtask

  task automatic model_step(input bit c, input bit cm, input bit i, input bit d);
    int s;
    m_ack = 0;
    if (c) begin
      model_reset();
    end else if (m_ovf) begin
      // locked until clear
    end else if (cm && m_count < MAXD) begin
      s = m_value * 10 + m_digit;
      if (s > VMAX) m_ovf = 1;
      else begin
        m_bcd   = {m_bcd[MAXD*4-5:0], 4'(m_digit)};
        m_value = s; m_count++; m_digit = 0; m_ack = 1;
      end
    end else begin
      if (i && !d) m_digit = (m_digit + 1) % 10;
      if (d && !i) m_digit = (m_digit + 9) % 10;
    end
  endtask

  task automatic apply(input bit c, input bit cm, input bit i, input bit d);
    @(negedge clk);
    bus.clr_pulse = c; bus.commit_pulse = cm; bus.inc_pulse = i; bus.dec_pulse = d;
    @(posedge clk);
    model_step(c, cm, i, d);
    #1;
    bus.clr_pulse = 0; bus.commit_pulse = 0; bus.inc_pulse = 0; bus.dec_pulse = 0;
    if (bus.commit_ack === 1'b1) dut_acks++;
    $display("txn clr=%0b commit=%0b inc=%0b dec=%0b -> digit=%0d count=%0d value=%0d full=%0b ovf=%0b ack=%0b",
             c, cm, i, d, bus.digit, bus.count, bus.value, bus.full, bus.ovf, bus.commit_ack);
  endtask

  task automatic enter_digit(input int dg);
    for (int k = 0; k < dg; k++) apply(0, 0, 1, 0);
    apply(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    bus.inc_pulse = 1; bus.commit_pulse = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus.digit, bus.count, bus.value, bus.full, bus.ovf, bus.commit_ack} !== '0) begin
      n_err++;
      $display("FAIL reset_state got digit=%0d count=%0d value=%0d full=%0b ovf=%0b ack=%0b exp all 0",
               bus.digit, bus.count, bus.value, bus.full, bus.ovf, bus.commit_ack);
    end
    bus.inc_pulse = 0; bus.commit_pulse = 0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 9; k++) apply(0, 0, 1, 0);
    n_vec++; if (bus.digit !== 4'd9) begin n_err++; $display("FAIL wrap_9inc got %0d exp 9", bus.digit); end
    apply(0, 0, 1, 0);
    n_vec++; if (bus.digit !== 4'd0) begin n_err++; $display("FAIL wrap_inc9 got %0d exp 0", bus.digit); end
    apply(0, 0, 0, 1);
    n_vec++; if (bus.digit !== 4'd9) begin n_err++; $display("FAIL wrap_dec0 got %0d exp 9", bus.digit); end
    apply(0, 0, 1, 1);
    n_vec++; if (bus.digit !== 4'd9) begin n_err++; $display("FAIL inc_dec_same got %0d exp 9", bus.digit); end
  endtask

  task automatic test_max();
    int d[5] = '{6, 5, 5, 3, 5};
    apply(1, 0, 0, 0);
    dut_acks = 0;
    foreach (d[k]) enter_digit(d[k]);
    n_vec++; if (bus.value !== 16'd65535) begin n_err++; $display("FAIL max_value got %0d exp 65535", bus.value); end
    n_vec++; if (bus.count !== CW'(5)) begin n_err++; $display("FAIL max_count got %0d exp 5", bus.count); end
    n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL max_full got %0b exp 1", bus.full); end
    n_vec++; if (dut_acks != 5) begin n_err++; $display("FAIL max_acks got %0d exp 5", dut_acks); end
`ifdef DEC_ENTRY_BCD_EN
    n_vec++; if (bus.bcd !== 20'h65535) begin n_err++; $display("FAIL max_bcd got %h exp 65535", bus.bcd); end
`endif
  endtask

  task automatic test_overflow();
    int d[4] = '{6, 5, 5, 3};
    apply(1, 0, 0, 0);
    foreach (d[k]) enter_digit(d[k]);
    dut_acks = 0;
    enter_digit(6);
    apply(0, 0, 1, 0);
    apply(0, 1, 0, 0);
    n_vec++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b exp 1", bus.ovf); end
    n_vec++; if (bus.value !== 16'd6553) begin n_err++; $display("FAIL ovf_value got %0d exp 6553", bus.value); end
    n_vec++; if (bus.count !== CW'(4)) begin n_err++; $display("FAIL ovf_count got %0d exp 4", bus.count); end
    n_vec++; if (bus.digit !== 4'd6) begin n_err++; $display("FAIL ovf_digit got %0d exp 6", bus.digit); end
    n_vec++; if (dut_acks != 0) begin n_err++; $display("FAIL ovf_acks got %0d exp 0", dut_acks); end
  endtask

  task automatic test_full();
    apply(1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) enter_digit(k);
    n_vec++; if (bus.value !== 16'd12345) begin n_err++; $display("FAIL full_value got %0d exp 12345", bus.value); end
    n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL full_flag got %0b exp 1", bus.full); end
    dut_acks = 0;
    enter_digit(6);
    n_vec++; if (dut_acks != 0) begin n_err++; $display("FAIL full_6th_ack got %0d exp 0", dut_acks); end
    n_vec++; if (bus.value !== 16'd12345 || bus.ovf !== 1'b0) begin
      n_err++; $display("FAIL full_6th_hold got value=%0d ovf=%0b exp 12345/0", bus.value, bus.ovf);
    end
  endtask

  task automatic test_clear_priority();
    apply(1, 0, 0, 0);
    enter_digit(4); enter_digit(2);
    for (int k = 0; k < 3; k++) apply(0, 0, 1, 0);
    apply(1, 1, 0, 0);
    n_vec++;
    if (bus.value !== '0 || bus.count !== '0 || bus.digit !== '0 || bus.commit_ack !== 1'b0) begin
      n_err++; $display("FAIL clr_over_commit got value=%0d count=%0d digit=%0d ack=%0b exp 0/0/0/0",
                        bus.value, bus.count, bus.digit, bus.commit_ack);
    end
    enter_digit(9); enter_digit(9); enter_digit(9); enter_digit(9); enter_digit(9);
    n_vec++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL clr_setup_ovf got %0b exp 1", bus.ovf); end
    apply(1, 0, 0, 0);
    n_vec++; if (bus.ovf !== 1'b0 || bus.value !== '0) begin
      n_err++; $display("FAIL clr_from_error got ovf=%0b value=%0d exp 0/0", bus.ovf, bus.value);
    end
  endtask

  task automatic test_async_reset();
    apply(1, 0, 0, 0);
    enter_digit(1); enter_digit(2); enter_digit(3);
    for (int k = 0; k < 7; k++) apply(0, 0, 1, 0);
    n_vec++; if (bus.value !== 16'd123 || bus.digit !== 4'd7) begin
      n_err++; $display("FAIL async_setup got value=%0d digit=%0d exp 123/7", bus.value, bus.digit);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.digit, bus.count, bus.value, bus.full, bus.ovf, bus.commit_ack} !== '0) begin
      n_err++; $display("FAIL async_reset got digit=%0d count=%0d value=%0d exp all 0", bus.digit, bus.count, bus.value);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit c, cm, i, d;
    for (int n = 0; n < 600; n++) begin
      c  = ($urandom_range(0, 39) == 0);
      cm = ($urandom_range(0, 3) == 0);
      i  = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 2) == 0);
      apply(c, cm, i, d);
      n_vec++; if (bus.value !== 16'(m_value)) begin n_err++; $display("FAIL rnd_value[%0d] got %0d exp %0d", n, bus.value, m_value); end
      n_vec++; if (bus.digit !== 4'(m_digit)) begin n_err++; $display("FAIL rnd_digit[%0d] got %0d exp %0d", n, bus.digit, m_digit); end
      n_vec++; if (bus.count !== CW'(m_count)) begin n_err++; $display("FAIL rnd_count[%0d] got %0d exp %0d", n, bus.count, m_count); end
      n_vec++; if (bus.full !== (m_count == MAXD)) begin n_err++; $display("FAIL rnd_full[%0d] got %0b exp %0b", n, bus.full, m_count == MAXD); end
      n_vec++; if (bus.ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf[%0d] got %0b exp %0b", n, bus.ovf, m_ovf); end
      n_vec++; if (bus.commit_ack !== m_ack) begin n_err++; $display("FAIL rnd_ack[%0d] got %0b exp %0b", n, bus.commit_ack, m_ack); end
`ifdef DEC_ENTRY_BCD_EN
      n_vec++; if (bus.bcd !== m_bcd) begin n_err++; $display("FAIL rnd_bcd[%0d] got %h exp %h", n, bus.bcd, m_bcd); end
`endif
    end
  endtask

  initial begin
    bus.inc_pulse = 0; bus.dec_pulse = 0; bus.commit_pulse = 0; bus.clr_pulse = 0;
    model_reset();
    test_reset();
    test_wrap();
    test_max();
    test_overflow();
    test_full();
    test_clear_priority();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
